// File: rtl/time_disp_pkg.sv
// Shared constants and BCD-to-segment lookup for the HH:MM:SS scan driver.
package time_disp_pkg;

  localparam int NUM_DIGITS = 6;

  typedef enum logic [2:0] {
    SLOT_HT = 3'd0,
    SLOT_HO = 3'd1,
    SLOT_MT = 3'd2,
    SLOT_MO = 3'd3,
    SLOT_ST = 3'd4,
    SLOT_SO = 3'd5
  } slot_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash so bad counter values are visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment pattern.
module bcd_to_seg7
  import time_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg_n
);

  assign o_seg_n = bcd_to_seg(i_bcd);

endmodule

// File: rtl/time_display_scan.sv
// Multiplexed 6-digit common-anode scan driver with per-frame snapshot and field blink.
// Optional: define LEADING_ZERO_BLANK_EN to blank a zero hour-tens digit.
module time_display_scan
  import time_disp_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLINK_HZ  = 2,
  parameter int GUARD_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hour_tens,
  input  logic [3:0] hour_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  input  logic [2:0] blink_mask,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] dig_sel_n
);

  localparam int PRE_MAX   = CLK_HZ / SCAN_HZ;
  localparam int BLINK_MAX = CLK_HZ / (2 * BLINK_HZ);
  localparam int PRE_W     = (PRE_MAX > 1) ? $clog2(PRE_MAX) : 1;
  localparam int BLINK_W   = (BLINK_MAX > 1) ? $clog2(BLINK_MAX) : 1;

  logic [PRE_W-1:0]   r_pre;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  slot_e              r_idx;
  logic [3:0]         r_snap [NUM_DIGITS];
  logic [6:0]         r_seg_n;
  logic               r_dp_n;
  logic [5:0]         r_dig_sel_n;

  logic       w_tick;
  logic       w_blink_tgl;
  logic       w_guard;
  logic [3:0] w_digit;
  logic       w_field_blink;
  logic       w_blink_blank;
  logic       w_lz_blank;
  logic       w_colon;
  logic [6:0] w_dec_seg;
  logic [6:0] w_seg_next;
  logic       w_dp_next;
  logic [5:0] w_dig_next;

  assign w_tick      = (r_pre == PRE_W'(PRE_MAX - 1));
  assign w_blink_tgl = (r_blink_cnt == BLINK_W'(BLINK_MAX - 1));
  assign w_guard     = (r_pre < PRE_W'(GUARD_CYC));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_digit       = r_snap[0];
    w_field_blink = 1'b0;
    case (r_idx)
      SLOT_HT: begin w_digit = r_snap[0]; w_field_blink = blink_mask[2]; end
      SLOT_HO: begin w_digit = r_snap[1]; w_field_blink = blink_mask[2]; end
      SLOT_MT: begin w_digit = r_snap[2]; w_field_blink = blink_mask[1]; end
      SLOT_MO: begin w_digit = r_snap[3]; w_field_blink = blink_mask[1]; end
      SLOT_ST: begin w_digit = r_snap[4]; w_field_blink = blink_mask[0]; end
      SLOT_SO: begin w_digit = r_snap[5]; w_field_blink = blink_mask[0]; end
      default: begin w_digit = r_snap[0]; w_field_blink = 1'b0; end
    endcase
  end

  bcd_to_seg7 u_dec (
    .i_bcd   (w_digit),
    .o_seg_n (w_dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign w_lz_blank = (r_idx == SLOT_HT) && (w_digit == 4'd0);
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_blink_blank = r_blink_phase & w_field_blink;
  assign w_colon       = (r_idx == SLOT_HO) || (r_idx == SLOT_MO);
  assign w_seg_next    = (w_guard || w_blink_blank || w_lz_blank) ? SEG_BLANK : w_dec_seg;
  assign w_dp_next     = ~(w_colon & ~w_guard & ~w_blink_blank);
  assign w_dig_next    = w_guard ? 6'h3F : ~(6'b00_0001 << r_idx);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre         <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_idx         <= SLOT_HT;
      // NOTE: the snapshot array is reset so the first frame after reset reads 00 00 00.
      for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= 4'd0;
      r_seg_n       <= SEG_BLANK;
      r_dp_n        <= 1'b1;
      r_dig_sel_n   <= 6'h3F;
    end else begin
      r_pre       <= w_tick ? '0 : r_pre + PRE_W'(1);
      r_blink_cnt <= w_blink_tgl ? '0 : r_blink_cnt + BLINK_W'(1);
      if (w_blink_tgl) r_blink_phase <= ~r_blink_phase;

      if (w_tick) r_idx <= (r_idx == SLOT_SO) ? SLOT_HT : slot_e'(r_idx + 3'd1);

      // Frame boundary: capture all digits together so a carry ripple is never shown torn.
      if (w_tick && (r_idx == SLOT_SO)) begin
        r_snap[0] <= hour_tens;
        r_snap[1] <= hour_ones;
        r_snap[2] <= min_tens;
        r_snap[3] <= min_ones;
        r_snap[4] <= sec_tens;
        r_snap[5] <= sec_ones;
      end

      r_seg_n     <= w_seg_next;
      r_dp_n      <= w_dp_next;
      r_dig_sel_n <= w_dig_next;
    end
  end

  assign seg_n     = r_seg_n;
  assign dp_n      = r_dp_n;
  assign dig_sel_n = r_dig_sel_n;

endmodule

// File: tb/tb_time_display_scan.sv
// Self-checking bench: cycle-count reference model of the scan driver with randomized digits and mask.
module tb_time_display_scan;

  localparam int CLK_HZ    = 1000;
  localparam int SCAN_HZ   = 100;
  localparam int BLINK_HZ  = 5;
  localparam int GUARD_CYC = 2;
  localparam int P         = CLK_HZ / SCAN_HZ;
  localparam int HALF_BLK  = CLK_HZ / (2 * BLINK_HZ);
  localparam int FRAME     = 6 * P;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones;
  logic [2:0] blink_mask;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] dig_sel_n;

  time_display_scan #(
    .CLK_HZ    (CLK_HZ),
    .SCAN_HZ   (SCAN_HZ),
    .BLINK_HZ  (BLINK_HZ),
    .GUARD_CYC (GUARD_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hour_tens  (hour_tens),
    .hour_ones  (hour_ones),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .blink_mask (blink_mask),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .dig_sel_n  (dig_sel_n)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         k      = 0;
  logic [3:0] snap [6];
  logic [6:0] seg_tab [16];
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic [5:0] exp_dig;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  // Expected outputs after clock edge k reflect the counters as they stood after k-1 edges.
  task automatic model_expect();
    int pre, idx, phase, n;
    logic blink, guard;
    logic [2:0] m;
    n     = k - 1;
    pre   = n % P;
    idx   = (n / P) % 6;
    phase = (n / HALF_BLK) % 2;
    m     = blink_mask;
    guard = (pre < GUARD_CYC);
    blink = (phase == 1) && m[2 - idx / 2];
    exp_dig = guard ? 6'h3F : (6'h3F ^ (6'(1) << idx));
    exp_dp  = !((idx == 1 || idx == 3) && !guard && !blink);
    if (guard || blink) exp_seg = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
    else if (idx == 0 && snap[0] == 4'd0) exp_seg = 7'h7F;
`endif
    else exp_seg = seg_tab[snap[idx]];
  endtask

  task automatic cycle();
    @(posedge clk);
    k++;
    model_expect();
    if ((k - 1) % FRAME == FRAME - 1) begin
      snap[0] = hour_tens; snap[1] = hour_ones;
      snap[2] = min_tens;  snap[3] = min_ones;
      snap[4] = sec_tens;  snap[5] = sec_ones;
    end
    @(negedge clk);
    check("seg_n", 32'(seg_n), 32'(exp_seg));
    check("dp_n", 32'(dp_n), 32'(exp_dp));
    check("dig_sel_n", 32'(dig_sel_n), 32'(exp_dig));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_time(input int hh, input int mm, input int ss);
    hour_tens = 4'(hh / 10); hour_ones = 4'(hh % 10);
    min_tens  = 4'(mm / 10); min_ones  = 4'(mm % 10);
    sec_tens  = 4'(ss / 10); sec_ones  = 4'(ss % 10);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_seg"}, 32'(seg_n), 32'h7F);
    check({tag, "_dp"}, 32'(dp_n), 32'h1);
    check({tag, "_dig"}, 32'(dig_sel_n), 32'h3F);
  endtask

  task automatic release_reset();
    reset = 1'b1;
    k = 0;
    for (int i = 0; i < 6; i++) snap[i] = 4'd0;
  endtask

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h3F;

    reset      = 1'b0;
    blink_mask = 3'b000;
    set_time(12, 34, 56);
    repeat (5) begin
      @(negedge clk);
      check_reset_vals("in_reset");
    end
    release_reset();

    // Frame 0 shows zeros, frame 1 shows 12:34:56.
    run(2 * FRAME);

    // min_ones changes mid slot 2: current frame keeps 4, next frame shows 5.
    run(2 * P + 5);
    min_ones = 4'd5;
    run(FRAME - (2 * P + 5));
    run(FRAME);

    // Minutes blink across several phase toggles.
    blink_mask = 3'b010;
    run(4 * HALF_BLK);
    blink_mask = 3'b000;

    // Out-of-range digit shows a dash.
    sec_tens = 4'hC;
    run(2 * FRAME);

    // Randomized digits, including non-BCD codes, and live blink masks.
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        hour_tens = 4'($urandom_range(0, 15)); hour_ones = 4'($urandom_range(0, 15));
        min_tens  = 4'($urandom_range(0, 15)); min_ones  = 4'($urandom_range(0, 15));
        sec_tens  = 4'($urandom_range(0, 15)); sec_ones  = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 39) == 0) blink_mask = 3'($urandom_range(0, 7));
      cycle();
    end

    // Leading zero hour.
    blink_mask = 3'b000;
    set_time(5, 0, 0);
    run(2 * FRAME);

    // Reset asserted mid slot 4 takes effect before the next clock edge.
    for (int i = 0; i < FRAME && !(((k / P) % 6 == 4) && (k % P == 5)); i++) cycle();
    check("reached_slot4", 32'((k / P) % 6), 32'd4);
    #2 reset = 1'b0;
    #1 check_reset_vals("async_reset");
    @(negedge clk);
    check_reset_vals("held_reset");
    release_reset();
    run(2 * FRAME + 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
